// File: rtl/ram_bist_pkg.sv
// Shared types and constants for the RAM march-test controller.
package ram_bist_pkg;

   localparam int DW_DEF = 8;
   localparam int AW_DEF = 6;
   localparam int CNT_W  = 8;

   typedef enum logic [3:0] {
      IDLE,
      W0,
      M1_RD,
      M1_WR,
      M2_RD,
      M2_WR,
      M3_RD,
      M3_CHK,
      DONE
   } state_t;

endpackage

// File: rtl/ram_bist_addr_gen.sv
// Up/down address counter with load, step and terminal flag for the march engine.
module ram_bist_addr_gen
   import ram_bist_pkg::*;
#(
   parameter int AW = AW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [AW-1:0] load_val,
   input  logic          step,
   input  logic          up,
   output logic [AW-1:0] addr,
   output logic [AW-1:0] addr_nxt,
   output logic          last
);

   // The controller never steps past the terminal address, so there is no wrap.
   always_comb begin
      addr_nxt = addr;
      if (load)
         addr_nxt = load_val;
      else if (step)
         addr_nxt = up ? addr + 1'b1 : addr - 1'b1;
   end

   assign last = up ? (addr == {AW{1'b1}}) : (addr == {AW{1'b0}});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         addr <= '0;
      else
         addr <= addr_nxt;
   end

endmodule

// File: rtl/ram_bist_ctrl.sv
// March BIST engine for a single-port RAM with registered address.
// Optional build macro RAM_BIST_ADDR_PATTERN_EN: background pattern XORed with the address.
//
// state  | meaning
// IDLE   | waiting for start after reset
// W0     | ascending write of P(a)
// M1_RD  | ascending read address phase
// M1_WR  | check P(a), write ~P(a)
// M2_RD  | descending read address phase
// M2_WR  | check ~P(a), write P(a)
// M3_RD  | ascending read address phase
// M3_CHK | check P(a), no write
// DONE   | results valid, waiting for start
module ram_bist_ctrl
   import ram_bist_pkg::*;
#(
   parameter int             DW           = DW_DEF,
   parameter int             AW           = AW_DEF,
   parameter logic [DW-1:0]  PATTERN      = 8'h55,
   parameter bit             STOP_ON_FAIL = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] err_cnt,
   output logic [AW-1:0]    fail_addr,
   output logic [DW-1:0]    fail_data,
   output logic [DW-1:0]    ram_data,
   output logic [AW-1:0]    ram_addr,
   output logic             ram_we,
   input  logic [DW-1:0]    ram_q
);

`ifdef RAM_BIST_ADDR_PATTERN_EN
   localparam logic [DW-1:0] ADDR_MASK = '1;
`else
   localparam logic [DW-1:0] ADDR_MASK = '0;
`endif

   function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
      return PATTERN ^ (ADDR_MASK & {{(DW-AW){1'b0}}, a});
   endfunction

   state_t           state, next_state;
   logic             ld, stp, up, last;
   logic [AW-1:0]    ld_val, addr, addr_nxt;
   logic             cmp_en, mis;
   logic [DW-1:0]    exp_val;
   logic [CNT_W-1:0] err_nxt;
   logic             we_d;
   logic [DW-1:0]    data_d;

   ram_bist_addr_gen #(.AW(AW)) u_addr_gen (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (ld),
      .load_val (ld_val),
      .step     (stp),
      .up       (up),
      .addr     (addr),
      .addr_nxt (addr_nxt),
      .last     (last)
   );

   assign ram_addr = addr;

   // Read data for the address driven in the previous (RD) cycle is on ram_q now.
   always_comb begin
      cmp_en  = 1'b0;
      exp_val = pat(addr);
      case (state)
         M1_WR:   cmp_en = 1'b1;
         M2_WR:   begin cmp_en = 1'b1; exp_val = ~pat(addr); end
         M3_CHK:  cmp_en = 1'b1;
         default: cmp_en = 1'b0;
      endcase
   end

   assign mis = cmp_en && (ram_q != exp_val);

   always_comb begin
      next_state = state;
      ld         = 1'b0;
      ld_val     = '0;
      stp        = 1'b0;
      up         = 1'b1;
      case (state)
         IDLE, DONE: if (start) begin next_state = W0; ld = 1'b1; end
         W0: begin
            if (last) begin next_state = M1_RD; ld = 1'b1; end
            else stp = 1'b1;
         end
         M1_RD: next_state = M1_WR;
         M1_WR: begin
            if (mis && STOP_ON_FAIL) next_state = DONE;
            else if (last) begin next_state = M2_RD; ld = 1'b1; ld_val = '1; end
            else begin next_state = M1_RD; stp = 1'b1; end
         end
         M2_RD: begin up = 1'b0; next_state = M2_WR; end
         M2_WR: begin
            up = 1'b0;
            if (mis && STOP_ON_FAIL) next_state = DONE;
            else if (last) begin next_state = M3_RD; ld = 1'b1; end
            else begin next_state = M2_RD; stp = 1'b1; end
         end
         M3_RD: next_state = M3_CHK;
         M3_CHK: begin
            if ((mis && STOP_ON_FAIL) || last) next_state = DONE;
            else begin next_state = M3_RD; stp = 1'b1; end
         end
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      err_nxt = err_cnt;
      if ((state == IDLE || state == DONE) && start)
         err_nxt = '0;
      else if (mis && err_cnt != {CNT_W{1'b1}})
         err_nxt = err_cnt + 1'b1;
   end

   always_comb begin
      we_d   = 1'b0;
      data_d = '0;
      case (next_state)
         W0, M2_WR: begin we_d = 1'b1; data_d = pat(addr_nxt); end
         M1_WR:     begin we_d = 1'b1; data_d = ~pat(addr_nxt); end
         default:   begin we_d = 1'b0; data_d = '0; end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         err_cnt   <= '0;
         fail_addr <= '0;
         fail_data <= '0;
         ram_we    <= 1'b0;
         ram_data  <= '0;
      end else begin
         state    <= next_state;
         busy     <= !(next_state == IDLE || next_state == DONE);
         done     <= (next_state == DONE);
         pass     <= (next_state == DONE) && (err_nxt == '0);
         err_cnt  <= err_nxt;
         ram_we   <= we_d;
         ram_data <= data_d;
         if ((state == IDLE || state == DONE) && start) begin
            fail_addr <= '0;
            fail_data <= '0;
         end else if (mis && err_cnt == '0) begin
            fail_addr <= addr;
            fail_data <= ram_q;
         end
      end
   end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Directed bench: two BIST instances (stop-on-fail and run-to-end) each driving its own RAM model.
module tb_ram_bist_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       stuck_en, alias_en;

   logic       s_busy, s_done, s_pass, s_we;
   logic [7:0] s_err, s_data, s_q;
   logic [5:0] s_fail_addr, s_addr;
   logic [7:0] s_fail_data;
   logic       r_busy, r_done, r_pass, r_we;
   logic [7:0] r_err, r_data, r_q;
   logic [5:0] r_fail_addr, r_addr;
   logic [7:0] r_fail_data;

   logic [7:0] mem_s [64];
   logic [7:0] mem_r [64];
   logic [5:0] aq_s, aq_r;

   int n_chk = 0;
   int n_err = 0;
   int ds, dr;

   always #5 clk = ~clk;

   ram_bist_ctrl #(.DW(8), .AW(6), .PATTERN(8'h55), .STOP_ON_FAIL(1'b1)) u_stop (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(s_busy), .done(s_done),
      .pass(s_pass), .err_cnt(s_err), .fail_addr(s_fail_addr), .fail_data(s_fail_data),
      .ram_data(s_data), .ram_addr(s_addr), .ram_we(s_we), .ram_q(s_q));

   ram_bist_ctrl #(.DW(8), .AW(6), .PATTERN(8'h55), .STOP_ON_FAIL(1'b0)) u_run (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(r_busy), .done(r_done),
      .pass(r_pass), .err_cnt(r_err), .fail_addr(r_fail_addr), .fail_data(r_fail_data),
      .ram_data(r_data), .ram_addr(r_addr), .ram_we(r_we), .ram_q(r_q));

   function automatic logic [5:0] eff(input logic [5:0] a);
      return alias_en ? {a[5:1], 1'b0} : a;
   endfunction

   function automatic logic [7:0] rd(input logic [7:0] v, input logic [5:0] a);
      return (stuck_en && a == 6'h11) ? (v & 8'hFE) : v;
   endfunction

   always @(posedge clk) begin
      if (s_we) mem_s[eff(s_addr)] <= s_data;
      if (r_we) mem_r[eff(r_addr)] <= r_data;
      aq_s <= s_addr;
      aq_r <= r_addr;
   end

   assign s_q = rd(mem_s[eff(aq_s)], aq_s);
   assign r_q = rd(mem_r[eff(aq_r)], aq_r);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Pulse start, then record the cycle at which each instance first shows done.
   task automatic run_test(input int pulse_at, output int d_s, output int d_r);
      int n;
      d_s = 0;
      d_r = 0;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      n = 1;
      check("start_busy", 32'(s_busy), 1);
      check("start_done", 32'(s_done), 0);
      check("start_err_clr", 32'(s_err), 0);
      check("start_faddr_clr", 32'(s_fail_addr), 0);
      check("start_fdata_clr", 32'(s_fail_data), 0);
      while ((d_s == 0 || d_r == 0) && n < 1000) begin
         if (d_s == 0 && s_done) d_s = n;
         if (d_r == 0 && r_done) d_r = n;
         start = (n == pulse_at);
         @(negedge clk);
         n++;
      end
      start = 1'b0;
   endtask

   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      stuck_en = 1'b0;
      alias_en = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(s_busy), 0);
      check("rst_done", 32'(s_done), 0);
      check("rst_pass", 32'(s_pass), 0);
      check("rst_err", 32'(s_err), 0);
      check("rst_faddr", 32'(s_fail_addr), 0);
      check("rst_fdata", 32'(s_fail_data), 0);
      check("rst_we", 32'(s_we), 0);
      check("rst_addr", 32'(s_addr), 0);
      check("rst_data", 32'(s_data), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // fault-free
      run_test(0, ds, dr);
      check("ok_lat_s", 32'(ds), 449);
      check("ok_lat_r", 32'(dr), 449);
      check("ok_pass_s", 32'(s_pass), 1);
      check("ok_pass_r", 32'(r_pass), 1);
      check("ok_err_r", 32'(r_err), 0);
      check("ok_busy", 32'(s_busy), 0);
      check("ok_we", 32'(s_we), 0);

      // stuck-at-0 on bit 0 at 0x11
      stuck_en = 1'b1;
      run_test(0, ds, dr);
      check("sa_lat_s", 32'(ds), 101);
      check("sa_pass_s", 32'(s_pass), 0);
      check("sa_err_s", 32'(s_err), 1);
      check("sa_faddr_s", 32'(s_fail_addr), 32'h11);
      check("sa_fdata_s", 32'(s_fail_data), 32'h54);
      check("sa_lat_r", 32'(dr), 449);
      check("sa_pass_r", 32'(r_pass), 0);
      check("sa_err_r", 32'(r_err), 2);
      check("sa_faddr_r", 32'(r_fail_addr), 32'h11);
      check("sa_fdata_r", 32'(r_fail_data), 32'h54);

      // restart from DONE, start re-pulsed while busy
      stuck_en = 1'b0;
      run_test(10, ds, dr);
      check("rb_lat_s", 32'(ds), 449);
      check("rb_lat_r", 32'(dr), 449);
      check("rb_pass_s", 32'(s_pass), 1);
      check("rb_err_r", 32'(r_err), 0);

      // reset mid-test
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (199) @(negedge clk);
      check("mid_busy", 32'(s_busy), 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", 32'(s_busy), 0);
      check("mid_rst_we", 32'(s_we), 0);
      check("mid_rst_we_r", 32'(r_we), 0);
      check("mid_rst_addr", 32'(s_addr), 0);
      check("mid_rst_done", 32'(s_done), 0);
      @(negedge clk) rst_n = 1'b1;
      run_test(0, ds, dr);
      check("post_rst_lat", 32'(ds), 449);
      check("post_rst_pass", 32'(s_pass), 1);

      // address bit 0 aliased to 0
      alias_en = 1'b1;
      run_test(0, ds, dr);
      check("al_pass_s", 32'(s_pass), 0);
      check("al_pass_r", 32'(r_pass), 0);
      check("al_lat_r", 32'(dr), 449);
      check("al_err_s", 32'(s_err), 1);
`ifdef RAM_BIST_ADDR_PATTERN_EN
      check("al_lat_s", 32'(ds), 67);
      check("al_faddr_s", 32'(s_fail_addr), 0);
      check("al_fdata_s", 32'(s_fail_data), 32'h54);
`else
      check("al_lat_s", 32'(ds), 69);
      check("al_faddr_s", 32'(s_fail_addr), 1);
      check("al_fdata_s", 32'(s_fail_data), 32'hAA);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/ram_bist_ctrl.md
Name: ram_bist_ctrl

Overview:
- March-style built-in self-test engine that sits directly upstream of the 64x8 single-port RAM and drives its data, addr and we inputs.
- Checks the RAM's q output against expected values and reports pass/fail, the first failing address and data, and an error count.
- Used at power-up or on demand, before the functional datapath takes ownership of the RAM through an external mux.

Parameters:
- DW, 8, RAM data width.
- AW, 6, RAM address width; depth = 2**AW.
- PATTERN, 8'h55, base background pattern written in the first march element.
- STOP_ON_FAIL, 1, 1 = abort to DONE on first miscompare; 0 = run to completion, counting errors.

Ports:
- clk  in  1  rising-edge clock shared with the RAM.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin test; sampled only in IDLE or DONE.
- busy  out  1  high while the test runs.
- done  out  1  level; high from test end until the next accepted start.
- pass  out  1  valid when done=1; 1 = no miscompare.
- err_cnt  out  8  saturating miscompare count.
- fail_addr  out  AW  address of the first miscompare.
- fail_data  out  DW  q value at the first miscompare.
- ram_data  out  DW  to RAM data.
- ram_addr  out  AW  to RAM addr.
- ram_we  out  1  to RAM we.
- ram_q  in  DW  from RAM q.

Behaviour:
- RAM model relied on:
  - The RAM registers addr every clock.
  - q = mem[registered addr], so read data is valid in the cycle after the address is driven.
  - A write with we=1 at address A makes q show the new data on the following cycle.
- Reset (async, rst_n=0) sets: state IDLE; busy=0, done=0, pass=0, err_cnt=0, fail_addr=0, fail_data=0; ram_we=0, ram_addr=0, ram_data=0.
- All outputs are registered.
- Expected pattern P(a) = PATTERN. The complement is ~P(a).
- State machine:
  - IDLE: on start, go to W0. Clear err_cnt, fail_*, pass. Set addr=0, busy=1.
  - W0 (ascending): we=1, data=P(a), one address per cycle. After a=63, go to M1_RD with addr=0.
  - M1_RD (ascending): drive addr=a, we=0. Next state M1_WR.
  - M1_WR: compare ram_q against P(a). In the same cycle drive we=1, data=~P(a), addr=a. Then a+1 to M1_RD; after a=63, go to M2_RD with addr=63.
  - M2_RD / M2_WR (descending, 63 down to 0): expect ~P(a), write P(a). After a=0, go to M3_RD with addr=0.
  - M3_RD / M3_CHK (ascending): expect P(a), no write. After a=63, go to DONE.
  - DONE: busy=0, done=1, pass=(err_cnt==0). we=0. Start re-enters W0 exactly as from IDLE.
- Compare cycles are M1_WR, M2_WR and M3_CHK.
- On a miscompare:
  - err_cnt increments, saturating at 255.
  - If err_cnt was 0, fail_addr and fail_data are latched.
  - If STOP_ON_FAIL=1, go to DONE on the next cycle with pass=0. That miscompare's write is still issued.
- Latency from start accepted to done=1, fault-free: 64 + 128 + 128 + 128 = 448 cycles of march states, plus 1 cycle to DONE.
- start while busy=1 is ignored. start held high in DONE restarts the test every completion.
- Address counter: AW bits with explicit terminal detection at 63 (ascending) or 0 (descending). It never wraps silently.
- Reset asserted mid-test: immediate return to IDLE with we=0. RAM contents are undefined afterwards.
- ram_we is never high outside W0, M1_WR and M2_WR.

Optional Feature:
- Macro: RAM_BIST_ADDR_PATTERN_EN.
- Defined: P(a) = PATTERN ^ {{(DW-AW){1'b0}}, a}, an address-unique background that detects address-decoder aliasing.
- Undefined: P(a) = PATTERN for all addresses.
- Cycle counts and the state machine are identical either way.

Decomposition:
- Package ram_bist_pkg holds:
  - the state enum: IDLE, W0, M1_RD, M1_WR, M2_RD, M2_WR, M3_RD, M3_CHK, DONE;
  - the DW/AW defaults;
  - the err_cnt width constant (8).
- One sub-module, ram_bist_addr_gen: up/down AW-bit counter with load, step and terminal flag.
- Compare and result-capture logic stay in the top.

Test Plan:
- Fault-free RAM, PATTERN=8'h55, start pulse -> busy for 448 cycles, then done=1, pass=1, err_cnt=0.
- Stuck-at-0 on bit 0 at addr 6'h11 (model forces q[0]=0 at that address), STOP_ON_FAIL=1 -> first miscompare in M1_WR at a=0x11; fail_addr=6'h11, fail_data=8'h54, pass=0, err_cnt=1, done well before 448 cycles.
- Same fault, STOP_ON_FAIL=0 -> full 449-cycle run; err_cnt=2 (M1 expects 8'h55, M3 expects 8'h55; M2 expects 8'hAA, bit0 already 0, matches); fail_addr=6'h11.
- rst_n pulsed low at cycle 200 of the test -> outputs immediately at reset values; a following start runs a full pass=1 test.
- start re-asserted during busy at cycle 10 -> ignored, completion at cycle 449. start in DONE -> err_cnt and fail_* cleared, new test begins.
- RAM_BIST_ADDR_PATTERN_EN defined, addr bit 0 aliased to 0 in the RAM model -> miscompare; pass=0.
